// File: rtl/ahbl_to_apb_if.sv
// AHB-Lite slave / APB master signal bundle for ahbl_to_apb; slave = bridge view,
// master = system view (drives AHB requests, acts as APB completer).
interface ahbl_to_apb_if #(
   parameter int W_HADDR = 32,
   parameter int W_PADDR = 16,
   parameter int W_DATA  = 32
);
   logic               ahbls_hready;
   logic               ahbls_hready_resp;
   logic               ahbls_hresp;
   logic [W_HADDR-1:0] ahbls_haddr;
   logic               ahbls_hwrite;
   logic [1:0]         ahbls_htrans;
   logic [2:0]         ahbls_hsize;
   logic [W_DATA-1:0]  ahbls_hwdata;
   logic [W_DATA-1:0]  ahbls_hrdata;

   logic [W_PADDR-1:0] apbm_paddr;
   logic               apbm_psel;
   logic               apbm_penable;
   logic               apbm_pwrite;
   logic [W_DATA-1:0]  apbm_pwdata;
   logic               apbm_pready;
   logic [W_DATA-1:0]  apbm_prdata;
   logic               apbm_pslverr;

   modport slave (
      input  ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans, ahbls_hsize, ahbls_hwdata,
      output ahbls_hready_resp, ahbls_hresp, ahbls_hrdata,
      output apbm_paddr, apbm_psel, apbm_penable, apbm_pwrite, apbm_pwdata,
      input  apbm_pready, apbm_prdata, apbm_pslverr
   );

   modport master (
      output ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans, ahbls_hsize, ahbls_hwdata,
      input  ahbls_hready_resp, ahbls_hresp, ahbls_hrdata,
      input  apbm_paddr, apbm_psel, apbm_penable, apbm_pwrite, apbm_pwdata,
      output apbm_pready, apbm_prdata, apbm_pslverr
   );
endinterface

// File: rtl/ahbl_to_apb.sv
// AHB-Lite single transfer -> APB SETUP/ACCESS; read done c3, write c4, +1 per APB wait; AHB held via hready_resp=0.
// AHBL_TO_APB_PSLVERR_EN maps pslverr to a two-cycle AHB ERROR; undefined, pslverr is ignored and hresp stays 0.
module ahbl_to_apb #(
   parameter int W_HADDR = 32,
   parameter int W_PADDR = 16,
   parameter int W_DATA  = 32
) (
   input logic           clk,
   input logic           rst_n,
   ahbl_to_apb_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WDATA,
      S_SETUP,
      S_ACCESS,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t             state;
   logic               hready_resp_q;
   logic               hresp_q;
   logic [W_DATA-1:0]  hrdata_q;
   logic               psel_q;
   logic               penable_q;
   logic               pwrite_q;
   logic [W_PADDR-1:0] paddr_q;
   logic [W_DATA-1:0]  pwdata_q;
   logic               capture;
   logic               unused_bits;

   // New transfers are only taken when the data phase of the previous one is finishing.
   assign capture = ((state == S_IDLE) || (state == S_ERR2)) &&
                    bus.ahbls_hready && bus.ahbls_htrans[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         hready_resp_q <= 1'b1;
         hresp_q       <= 1'b0;
         hrdata_q      <= '0;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
      end else begin
         case (state)
            S_IDLE, S_ERR2: begin
               hresp_q <= 1'b0;
               if (capture) begin
                  paddr_q       <= bus.ahbls_haddr[W_PADDR-1:0];
                  pwrite_q      <= bus.ahbls_hwrite;
                  hready_resp_q <= 1'b0;
                  if (bus.ahbls_hwrite) begin
                     state <= S_WDATA;
                  end else begin
                     state  <= S_SETUP;
                     psel_q <= 1'b1;
                  end
               end else begin
                  state         <= S_IDLE;
                  hready_resp_q <= 1'b1;
               end
            end
            S_WDATA: begin
               pwdata_q <= bus.ahbls_hwdata;
               psel_q   <= 1'b1;
               state    <= S_SETUP;
            end
            S_SETUP: begin
               penable_q <= 1'b1;
               state     <= S_ACCESS;
            end
            S_ACCESS: begin
               if (bus.apbm_pready) begin
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
`ifdef AHBL_TO_APB_PSLVERR_EN
                  if (bus.apbm_pslverr) begin
                     state   <= S_ERR1;
                     hresp_q <= 1'b1;
                  end else
`endif
                  begin
                     state         <= S_IDLE;
                     hready_resp_q <= 1'b1;
                     if (!pwrite_q) begin
                        hrdata_q <= bus.apbm_prdata;
                     end
                  end
               end
            end
            S_ERR1: begin
               // Second error cycle releases the master with hresp still high.
               state         <= S_ERR2;
               hready_resp_q <= 1'b1;
            end
            default: begin
               state         <= S_IDLE;
               hready_resp_q <= 1'b1;
               hresp_q       <= 1'b0;
               psel_q        <= 1'b0;
               penable_q     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ahbls_hready_resp = hready_resp_q;
   assign bus.ahbls_hresp       = hresp_q;
   assign bus.ahbls_hrdata      = hrdata_q;
   assign bus.apbm_paddr        = paddr_q;
   assign bus.apbm_psel         = psel_q;
   assign bus.apbm_penable      = penable_q;
   assign bus.apbm_pwrite       = pwrite_q;
   assign bus.apbm_pwdata       = pwdata_q;

`ifdef AHBL_TO_APB_PSLVERR_EN
   assign unused_bits = ^{bus.ahbls_hsize, bus.ahbls_htrans[0], bus.ahbls_haddr[W_HADDR-1:W_PADDR]};
`else
   assign unused_bits = ^{bus.ahbls_hsize, bus.ahbls_htrans[0], bus.ahbls_haddr[W_HADDR-1:W_PADDR],
                          bus.apbm_pslverr};
`endif

endmodule

// File: tb/tb_ahbl_to_apb.sv
// Bench for ahbl_to_apb: transaction-level latency/APB/response model against randomized traffic.
module tb_ahbl_to_apb;
   localparam int W_HADDR = 32;
   localparam int W_PADDR = 16;
   localparam int W_DATA  = 32;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          waits;
      logic [31:0] rdat;
      logic        err;
      int          gap;
   } txn_t;

   typedef struct {
      int          c0;
      int          t_psel;
      int          t_pen;
      int          n_pen;
      int          t_err1;
      int          t_done;
      logic [15:0] paddr;
      logic        pwrite;
      logic [31:0] pwdata;
      logic        unstable;
      logic [31:0] hrdata;
      logic        hresp;
   } res_t;

   logic        clk;
   logic        rst_n;
   int          vectors;
   int          miscompares;
   logic [31:0] last_rd;
   txn_t        tq[$];
   res_t        rq[$];
   int          idle_bad;
   bit          timed_out;

   ahbl_to_apb_if #(.W_HADDR(W_HADDR), .W_PADDR(W_PADDR), .W_DATA(W_DATA)) bus ();

   ahbl_to_apb #(.W_HADDR(W_HADDR), .W_PADDR(W_PADDR), .W_DATA(W_DATA)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: error mapping and end-to-end latency from the address cycle.
   function automatic bit err_taken(txn_t t);
`ifdef AHBL_TO_APB_PSLVERR_EN
      return t.err;
`else
      return 1'b0;
`endif
   endfunction

   function automatic int exp_setup(txn_t t);
      return t.wr ? 2 : 1;
   endfunction

   function automatic int exp_done(txn_t t);
      return (t.wr ? 4 : 3) + t.waits + (err_taken(t) ? 1 : 0);
   endfunction

   task automatic drive_idle();
      bus.ahbls_hready  = 1'b1;
      bus.ahbls_htrans  = 2'b00;
      bus.ahbls_haddr   = '0;
      bus.ahbls_hwrite  = 1'b0;
      bus.ahbls_hsize   = 3'd2;
      bus.ahbls_hwdata  = '0;
      bus.apbm_pready   = 1'b0;
      bus.apbm_prdata   = '0;
      bus.apbm_pslverr  = 1'b0;
   endtask

   // Plays tq as an AHB master plus APB completer; records observed timing into rq.
   task automatic run_seq();
      txn_t t;
      res_t r;
      int   k, rel, acc, gap_left, budget;
      bit   active;
      k = 0; acc = 0; rel = 0; active = 1'b0;
      idle_bad = 0; timed_out = 1'b0; rq.delete();
      t = '{default: 0};
      r = '{default: 0};
      budget = 20;
      foreach (tq[i]) budget += tq[i].gap + tq[i].waits + 8;
      gap_left = (tq.size() > 0) ? tq[0].gap : 0;
      while (active || tq.size() > 0) begin
         if (k > budget) begin
            timed_out = 1'b1;
            break;
         end
         rel = active ? k - r.c0 : 0;
         if (active && rel > 0) begin
            if (bus.apbm_psel === 1'b1 && r.t_psel < 0) begin
               r.t_psel = rel;
               r.paddr  = bus.apbm_paddr;
               r.pwrite = bus.apbm_pwrite;
               r.pwdata = bus.apbm_pwdata;
            end else if (bus.apbm_psel === 1'b1 &&
                         (bus.apbm_paddr !== r.paddr || bus.apbm_pwrite !== r.pwrite ||
                          bus.apbm_pwdata !== r.pwdata)) begin
               r.unstable = 1'b1;
            end
            if (bus.apbm_psel === 1'b1 && bus.apbm_penable === 1'b1) begin
               if (r.t_pen < 0) r.t_pen = rel;
               r.n_pen++;
            end
            if (bus.ahbls_hresp === 1'b1 && bus.ahbls_hready_resp === 1'b0 && r.t_err1 < 0)
               r.t_err1 = rel;
            if (bus.ahbls_hready_resp === 1'b1) begin
               r.t_done = rel;
               r.hrdata = bus.ahbls_hrdata;
               r.hresp  = bus.ahbls_hresp;
               rq.push_back(r);
               active = 1'b0;
               if (tq.size() > 0) gap_left = tq[0].gap;
            end
         end else if (!active) begin
            if (!(bus.ahbls_hready_resp === 1'b1 && bus.ahbls_hresp === 1'b0 &&
                  bus.apbm_psel === 1'b0 && bus.apbm_penable === 1'b0)) idle_bad++;
         end
         // Junk that must never start a transfer while idle
         bus.ahbls_htrans = 2'($urandom_range(0, 3));
         bus.ahbls_hready = bus.ahbls_htrans[1] ? 1'b0 : 1'($urandom);
         bus.ahbls_haddr  = $urandom;
         bus.ahbls_hwrite = 1'($urandom);
         bus.ahbls_hsize  = 3'($urandom);
         bus.ahbls_hwdata = $urandom;
         if (!active && tq.size() > 0) begin
            if (gap_left > 0) begin
               gap_left--;
            end else begin
               t = tq.pop_front();
               r = '{default: 0};
               r.c0 = k; r.t_psel = -1; r.t_pen = -1; r.t_err1 = -1; r.t_done = -1;
               active = 1'b1;
               acc = 0;
               bus.ahbls_hready = 1'b1;
               bus.ahbls_htrans = 2'b10;
               bus.ahbls_haddr  = t.addr;
               bus.ahbls_hwrite = t.wr;
            end
         end else if (active) begin
            bus.ahbls_htrans = 2'($urandom_range(0, 3));
            bus.ahbls_hready = 1'($urandom);
            if (rel == 1) bus.ahbls_hwdata = t.wdata;
         end
         bus.apbm_pready  = 1'($urandom);
         bus.apbm_prdata  = $urandom;
         bus.apbm_pslverr = 1'($urandom);
         if (active && bus.apbm_psel === 1'b1 && bus.apbm_penable === 1'b1) begin
            acc++;
            bus.apbm_pready = (acc > t.waits);
            if (acc > t.waits) begin
               bus.apbm_prdata  = t.rdat;
               bus.apbm_pslverr = t.err;
            end
         end
         @(posedge clk); #1;
         k++;
      end
      drive_idle();
      for (int i = 0; i < 2; i++) begin
         if (!(bus.ahbls_hready_resp === 1'b1 && bus.ahbls_hresp === 1'b0 &&
               bus.apbm_psel === 1'b0 && bus.apbm_penable === 1'b0)) idle_bad++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive_idle();
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({bus.ahbls_hready_resp, bus.ahbls_hresp, bus.apbm_psel, bus.apbm_penable, bus.apbm_pwrite} !== 5'b10000) begin
         miscompares++;
         $display("FAIL reset_ctrl: got rdy/resp/psel/pen/pwrite=%b want 10000",
                  {bus.ahbls_hready_resp, bus.ahbls_hresp, bus.apbm_psel, bus.apbm_penable, bus.apbm_pwrite});
      end
      vectors++;
      if (bus.apbm_paddr !== 16'h0) begin
         miscompares++; $display("FAIL reset_paddr: got %h want 0000", bus.apbm_paddr);
      end
      vectors++;
      if (bus.apbm_pwdata !== 32'h0) begin
         miscompares++; $display("FAIL reset_pwdata: got %h want 0", bus.apbm_pwdata);
      end
      vectors++;
      if (bus.ahbls_hrdata !== 32'h0) begin
         miscompares++; $display("FAIL reset_hrdata: got %h want 0", bus.ahbls_hrdata);
      end
      rst_n = 1'b1;
      last_rd = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_read();
      tq.delete();
      tq.push_back('{wr: 1'b0, addr: 32'h0000_4004, wdata: 32'h0, waits: 0, rdat: 32'hDEAD_BEEF, err: 1'b0, gap: 0});
      run_seq();
      vectors++;
      if (timed_out || rq.size() != 1) begin
         miscompares++; $display("FAIL read_complete: got %0d results timeout=%0d want 1", rq.size(), timed_out);
      end else begin
         vectors++;
         if (rq[0].t_psel !== 1 || rq[0].t_pen !== 2 || rq[0].t_done !== 3) begin
            miscompares++;
            $display("FAIL read_timing: got psel c%0d pen c%0d done c%0d want c1 c2 c3", rq[0].t_psel, rq[0].t_pen, rq[0].t_done);
         end
         vectors++;
         if (rq[0].hrdata !== 32'hDEAD_BEEF || rq[0].hresp !== 1'b0) begin
            miscompares++; $display("FAIL read_data: got %h resp %b want deadbeef resp 0", rq[0].hrdata, rq[0].hresp);
         end
         vectors++;
         if (rq[0].paddr !== 16'h4004 || rq[0].pwrite !== 1'b0) begin
            miscompares++; $display("FAIL read_apb: got paddr %h pwrite %b want 4004 0", rq[0].paddr, rq[0].pwrite);
         end
      end
      last_rd = 32'hDEAD_BEEF;
      vectors++;
      if (idle_bad != 0) begin
         miscompares++; $display("FAIL read_idle: got %0d bad idle cycles want 0", idle_bad);
      end
   endtask

   task automatic test_write_wait();
      tq.delete();
      tq.push_back('{wr: 1'b1, addr: 32'h0000_0010, wdata: 32'h1234_5678, waits: 2, rdat: 32'h0, err: 1'b0, gap: 1});
      run_seq();
      vectors++;
      if (timed_out || rq.size() != 1) begin
         miscompares++; $display("FAIL write_complete: got %0d results timeout=%0d want 1", rq.size(), timed_out);
      end else begin
         vectors++;
         if (rq[0].t_psel !== 2 || rq[0].pwdata !== 32'h1234_5678 || rq[0].unstable !== 1'b0) begin
            miscompares++;
            $display("FAIL write_pwdata: got psel c%0d pwdata %h unstable %b want c2 12345678 0",
                     rq[0].t_psel, rq[0].pwdata, rq[0].unstable);
         end
         vectors++;
         if (rq[0].n_pen !== 3 || rq[0].t_done !== 6) begin
            miscompares++; $display("FAIL write_waits: got penable %0d cycles done c%0d want 3 c6", rq[0].n_pen, rq[0].t_done);
         end
         vectors++;
         if (rq[0].paddr !== 16'h0010 || rq[0].pwrite !== 1'b1 || rq[0].hrdata !== last_rd) begin
            miscompares++;
            $display("FAIL write_apb: got paddr %h pwrite %b hrdata %h want 0010 1 %h",
                     rq[0].paddr, rq[0].pwrite, rq[0].hrdata, last_rd);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      rd = $urandom;
      tq.delete();
      tq.push_back('{wr: 1'b0, addr: 32'h0000_0000, wdata: 32'h0, waits: 0, rdat: rd, err: 1'b0, gap: 0});
      tq.push_back('{wr: 1'b1, addr: 32'h0000_0004, wdata: 32'hA5A5_0F0F, waits: 0, rdat: 32'h0, err: 1'b0, gap: 0});
      run_seq();
      vectors++;
      if (timed_out || rq.size() != 2) begin
         miscompares++; $display("FAIL b2b_complete: got %0d results timeout=%0d want 2", rq.size(), timed_out);
      end else begin
         vectors++;
         if (rq[0].hrdata !== rd || rq[0].t_done !== 3) begin
            miscompares++; $display("FAIL b2b_read: got %h at c%0d want %h at c3", rq[0].hrdata, rq[0].t_done, rd);
         end
         vectors++;
         if (rq[1].c0 !== rq[0].c0 + 3 || rq[1].t_psel !== 2 || rq[1].t_done !== 4) begin
            miscompares++;
            $display("FAIL b2b_nobubble: got accept +%0d psel c%0d done c%0d want +3 c2 c4",
                     rq[1].c0 - rq[0].c0, rq[1].t_psel, rq[1].t_done);
         end
         vectors++;
         if (rq[1].pwrite !== 1'b1 || rq[1].paddr !== 16'h0004 || rq[1].pwdata !== 32'hA5A5_0F0F) begin
            miscompares++;
            $display("FAIL b2b_apb: got pwrite %b paddr %h pwdata %h want 1 0004 a5a50f0f",
                     rq[1].pwrite, rq[1].paddr, rq[1].pwdata);
         end
      end
      last_rd = rd;
   endtask

   task automatic test_pslverr();
      txn_t txs[$];
      logic [31:0] exp_rd;
      txs.push_back('{wr: 1'b0, addr: 32'h0000_0100, wdata: 32'h0, waits: 0, rdat: 32'hBAD0_BAD0, err: 1'b1, gap: 0});
      txs.push_back('{wr: 1'b0, addr: 32'h0000_0104, wdata: 32'h0, waits: 0, rdat: 32'h1111_2222, err: 1'b0, gap: 0});
      txs.push_back('{wr: 1'b1, addr: 32'h0000_0108, wdata: 32'h3333_4444, waits: 1, rdat: 32'h0, err: 1'b1, gap: 1});
      tq = txs;
      run_seq();
      vectors++;
      if (timed_out || rq.size() != txs.size()) begin
         miscompares++; $display("FAIL err_complete: got %0d results timeout=%0d want %0d", rq.size(), timed_out, txs.size());
      end
      exp_rd = last_rd;
      for (int i = 0; i < rq.size() && i < txs.size(); i++) begin
         if (!txs[i].wr && !err_taken(txs[i])) exp_rd = txs[i].rdat;
         vectors++;
         if (rq[i].t_err1 !== (err_taken(txs[i]) ? exp_done(txs[i]) - 1 : -1) ||
             rq[i].t_done !== exp_done(txs[i]) || rq[i].hresp !== err_taken(txs[i])) begin
            miscompares++;
            $display("FAIL err_seq%0d: got err1 c%0d done c%0d hresp %b want err1 c%0d done c%0d hresp %b", i,
                     rq[i].t_err1, rq[i].t_done, rq[i].hresp,
                     err_taken(txs[i]) ? exp_done(txs[i]) - 1 : -1, exp_done(txs[i]), err_taken(txs[i]));
         end
         vectors++;
         if (rq[i].hrdata !== exp_rd) begin
            miscompares++; $display("FAIL err_hrdata%0d: got %h want %h", i, rq[i].hrdata, exp_rd);
         end
      end
      vectors++;
      if (rq.size() > 1 && rq[1].c0 !== rq[0].c0 + rq[0].t_done) begin
         miscompares++; $display("FAIL err_capture: got accept +%0d want +%0d", rq[1].c0 - rq[0].c0, rq[0].t_done);
      end
      vectors++;
      if (idle_bad != 0) begin
         miscompares++; $display("FAIL err_to_idle: got %0d bad idle cycles want 0", idle_bad);
      end
      last_rd = exp_rd;
   endtask

   task automatic test_idle_busy();
      for (int i = 0; i < 8; i++) begin
         bus.ahbls_htrans = 2'(i % 4);
         bus.ahbls_hready = (i % 4 < 2) ? 1'b1 : 1'b0;
         bus.ahbls_haddr  = $urandom;
         bus.ahbls_hwrite = 1'(i / 4);
         bus.apbm_pready  = 1'($urandom);
         @(posedge clk); #1;
         vectors++;
         if ({bus.apbm_psel, bus.apbm_penable, bus.ahbls_hready_resp, bus.ahbls_hresp} !== 4'b0010) begin
            miscompares++;
            $display("FAIL idle_busy%0d: got psel/pen/rdy/resp=%b want 0010", i,
                     {bus.apbm_psel, bus.apbm_penable, bus.ahbls_hready_resp, bus.ahbls_hresp});
         end
      end
      drive_idle();
      @(posedge clk); #1;
   endtask

   task automatic test_reset_abort();
      logic        reached;
      logic [31:0] rd;
      drive_idle();
      bus.ahbls_htrans = 2'b10;
      bus.ahbls_haddr  = 32'h0000_0020;
      bus.ahbls_hwrite = 1'b0;
      @(posedge clk); #1;
      bus.ahbls_htrans = 2'b00;
      reached = 1'b0;
      for (int n = 0; n < 8; n++) begin
         if (bus.apbm_psel === 1'b1 && bus.apbm_penable === 1'b1) begin
            reached = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      vectors++;
      if (reached !== 1'b1) begin
         miscompares++; $display("FAIL abort_access: got no ACCESS phase want ACCESS within 8 cycles");
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({bus.apbm_psel, bus.apbm_penable, bus.ahbls_hready_resp, bus.ahbls_hresp} !== 4'b0010) begin
         miscompares++;
         $display("FAIL abort_async: got psel/pen/rdy/resp=%b want 0010",
                  {bus.apbm_psel, bus.apbm_penable, bus.ahbls_hready_resp, bus.ahbls_hresp});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      last_rd = '0;
      @(posedge clk); #1;
      rd = $urandom;
      tq.delete();
      tq.push_back('{wr: 1'b0, addr: 32'h0000_0024, wdata: 32'h0, waits: 1, rdat: rd, err: 1'b0, gap: 0});
      run_seq();
      vectors++;
      if (timed_out || rq.size() != 1 || rq[0].t_done !== 4 || rq[0].hrdata !== rd) begin
         miscompares++;
         $display("FAIL abort_recover: got results %0d done c%0d hrdata %h want 1 c4 %h",
                  rq.size(), (rq.size() > 0) ? rq[0].t_done : -1, (rq.size() > 0) ? rq[0].hrdata : 32'h0, rd);
      end
      last_rd = rd;
   endtask

   task automatic test_random();
      txn_t        txs[$];
      txn_t        t;
      logic [31:0] exp_rd;
      int          ep;
      for (int i = 0; i < 40; i++) begin
         t.wr    = 1'($urandom);
         t.addr  = $urandom;
         t.wdata = $urandom;
         t.waits = $urandom_range(0, 3);
         t.rdat  = $urandom;
         t.err   = ($urandom_range(0, 3) == 0);
         t.gap   = $urandom_range(0, 2);
         txs.push_back(t);
      end
      tq = txs;
      run_seq();
      vectors++;
      if (timed_out || rq.size() != txs.size()) begin
         miscompares++; $display("FAIL rand_complete: got %0d results timeout=%0d want %0d", rq.size(), timed_out, txs.size());
      end
      vectors++;
      if (idle_bad != 0) begin
         miscompares++; $display("FAIL rand_idle: got %0d bad idle cycles want 0", idle_bad);
      end
      exp_rd = last_rd;
      for (int i = 0; i < rq.size() && i < txs.size(); i++) begin
         t  = txs[i];
         ep = exp_setup(t);
         if (!t.wr && !err_taken(t)) exp_rd = t.rdat;
         vectors++;
         if (rq[i].t_psel !== ep || rq[i].t_pen !== ep + 1 || rq[i].n_pen !== t.waits + 1 ||
             rq[i].t_err1 !== (err_taken(t) ? exp_done(t) - 1 : -1) || rq[i].t_done !== exp_done(t)) begin
            miscompares++;
            $display("FAIL rand_timing%0d: got psel %0d pen %0d npen %0d err1 %0d done %0d want %0d %0d %0d %0d %0d", i,
                     rq[i].t_psel, rq[i].t_pen, rq[i].n_pen, rq[i].t_err1, rq[i].t_done,
                     ep, ep + 1, t.waits + 1, err_taken(t) ? exp_done(t) - 1 : -1, exp_done(t));
         end
         vectors++;
         if (rq[i].paddr !== t.addr[15:0] || rq[i].pwrite !== t.wr || rq[i].unstable !== 1'b0 ||
             (t.wr && rq[i].pwdata !== t.wdata)) begin
            miscompares++;
            $display("FAIL rand_apb%0d: got paddr %h pwrite %b pwdata %h unstable %b want %h %b %h 0", i,
                     rq[i].paddr, rq[i].pwrite, rq[i].pwdata, rq[i].unstable, t.addr[15:0], t.wr, t.wdata);
         end
         vectors++;
         if (rq[i].hresp !== err_taken(t) || rq[i].hrdata !== exp_rd) begin
            miscompares++;
            $display("FAIL rand_resp%0d: got hresp %b hrdata %h want %b %h", i,
                     rq[i].hresp, rq[i].hrdata, err_taken(t), exp_rd);
         end
         if (i > 0) begin
            vectors++;
            if (rq[i].c0 !== rq[i-1].c0 + rq[i-1].t_done + t.gap) begin
               miscompares++;
               $display("FAIL rand_accept%0d: got c0 %0d want %0d", i, rq[i].c0, rq[i-1].c0 + rq[i-1].t_done + t.gap);
            end
         end
      end
      last_rd = exp_rd;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      last_rd     = '0;
      rst_n       = 1'b0;
      drive_idle();
      test_reset();
      test_read();
      test_write_wait();
      test_back_to_back();
      test_pslverr();
      test_idle_busy();
      test_reset_abort();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
